// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared types and helpers for the digit-serial arithmetic blocks
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width for n steps; a single-step counter still needs one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - digit-serial adder/subtractor, LSB digit first, valid/ready on both sides
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  import serial_arith_pkg::*;

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  generate
    if (WIDTH < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $fatal(1, "serial_addsub: WIDTH must be >= 1 and a multiple of DIGIT");
    end
  endgenerate

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry_reg;
  logic             a_msb;
  logic             bp_msb;

  logic [DIGIT:0]         chain_c;
  logic [DIGIT-1:0]       digit_sum;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0]       res_next;

  assign chain_c[0] = carry_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DIGIT; gi++) begin : g_chain
      full_adder u_fa (
        .a    (a_sr[gi]),
        .b    (b_sr[gi]),
        .cin  (chain_c[gi]),
        .sum  (digit_sum[gi]),
        .cout (chain_c[gi+1])
      );
    end
  endgenerate

  // New digit enters at the top; after NDIG shifts the LSB digit lands at bit 0.
  assign res_cat  = {digit_sum, res_sr};
  assign res_next = res_cat[WIDTH+DIGIT-1:DIGIT];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      carry_reg <= 1'b0;
      a_msb     <= 1'b0;
      bp_msb    <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            a_sr      <= a;
            b_sr      <= sub ? ~b : b;
            carry_reg <= sub;
            a_msb     <= a[WIDTH-1];
            bp_msb    <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
            count     <= '0;
            in_ready  <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          a_sr      <= a_sr >> DIGIT;
          b_sr      <= b_sr >> DIGIT;
          res_sr    <= res_next;
          carry_reg <= chain_c[DIGIT];
          count     <= count + ONE;
          if (count == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            sum       <= res_next;
            carry     <= chain_c[DIGIT];
            overflow  <= (a_msb == bp_msb) && (res_next[WIDTH-1] != a_msb);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - directed and random checks of serial_addsub at DIGIT = 1, 2 and 8
module tb_serial_addsub;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic       sub;
  logic       in_valid [3];
  logic       out_ready [3];
  logic       in_ready_o [3];
  logic       out_valid_o [3];
  logic [7:0] sum_o [3];
  logic       carry_o [3];
  logic       ovf_o [3];

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready_o[0]),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid_o[0]), .out_ready(out_ready[0]),
    .sum(sum_o[0]), .carry(carry_o[0]), .overflow(ovf_o[0])
  );

  serial_addsub #(.WIDTH(8), .DIGIT(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready_o[1]),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid_o[1]), .out_ready(out_ready[1]),
    .sum(sum_o[1]), .carry(carry_o[1]), .overflow(ovf_o[1])
  );

  serial_addsub #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready_o[2]),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid_o[2]), .out_ready(out_ready[2]),
    .sum(sum_o[2]), .carry(carry_o[2]), .overflow(ovf_o[2])
  );

  // Runs one operation on instance k and returns its result and latency in edges after accept.
  task automatic do_op(input int k, input logic [7:0] aa, input logic [7:0] bb, input logic s,
                       output logic [7:0] rs, output logic rc, output logic ro, output int lat);
    int n;
    n = 0;
    while (!in_ready_o[k] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (in_ready_o[k] !== 1'b1) $display("FAIL ready_wait[%0d]: in_ready=%b required 1", k, in_ready_o[k]);
    else pass_cnt++;
    a = aa; b = bb; sub = s; in_valid[k] = 1'b1;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    a = 8'hxx; b = 8'hxx; sub = 1'bx;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid_o[k] && lat < 20);
    rs = sum_o[k]; rc = carry_o[k]; ro = ovf_o[k];
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (in_ready_o[0] !== 1'b0) $display("FAIL reset_in_ready: got %b required 0", in_ready_o[0]);
    else pass_cnt++;
    total++;
    if (out_valid_o[0] !== 1'b0) $display("FAIL reset_out_valid: got %b required 0", out_valid_o[0]);
    else pass_cnt++;
    total++;
    if ({sum_o[0], carry_o[0], ovf_o[0]} !== 10'd0)
      $display("FAIL reset_outputs: got sum=%h c=%b o=%b required all 0", sum_o[0], carry_o[0], ovf_o[0]);
    else pass_cnt++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (in_ready_o[0] !== 1'b1) $display("FAIL release_in_ready: got %b required 1", in_ready_o[0]);
    else pass_cnt++;
  endtask

  task automatic test_add();
    logic [7:0] rs; logic rc, ro; int lat;
    do_op(0, 8'h03, 8'h05, 1'b0, rs, rc, ro, lat);
    total++;
    if (lat !== 8) $display("FAIL add_latency: got %0d required 8", lat);
    else pass_cnt++;
    total++;
    if ({rs, rc, ro} !== {8'h08, 1'b0, 1'b0})
      $display("FAIL add_03_05: got sum=%h c=%b o=%b required 08 0 0", rs, rc, ro);
    else pass_cnt++;
    do_op(0, 8'hFF, 8'h01, 1'b0, rs, rc, ro, lat);
    total++;
    if ({rs, rc, ro} !== {8'h00, 1'b1, 1'b0})
      $display("FAIL add_ff_01: got sum=%h c=%b o=%b required 00 1 0", rs, rc, ro);
    else pass_cnt++;
    do_op(0, 8'h7F, 8'h01, 1'b0, rs, rc, ro, lat);
    total++;
    if ({rs, rc, ro} !== {8'h80, 1'b0, 1'b1})
      $display("FAIL add_7f_01: got sum=%h c=%b o=%b required 80 0 1", rs, rc, ro);
    else pass_cnt++;
  endtask

  task automatic test_sub();
    logic [7:0] rs; logic rc, ro; int lat;
    do_op(0, 8'h05, 8'h07, 1'b1, rs, rc, ro, lat);
    total++;
    if ({rs, rc, ro} !== {8'hFE, 1'b0, 1'b0})
      $display("FAIL sub_05_07: got sum=%h c=%b o=%b required fe 0 0", rs, rc, ro);
    else pass_cnt++;
    do_op(0, 8'h80, 8'h01, 1'b1, rs, rc, ro, lat);
    total++;
    if ({rs, rc, ro} !== {8'h7F, 1'b1, 1'b1})
      $display("FAIL sub_80_01: got sum=%h c=%b o=%b required 7f 1 1", rs, rc, ro);
    else pass_cnt++;
  endtask

  task automatic test_digit_widths();
    logic [7:0] rs, aa, bb, bp, es; logic rc, ro, s, ec, eo; int lat;
    logic [8:0] full;
    for (int k = 1; k < 3; k++) begin
      for (int it = 0; it < 25; it++) begin
        aa = 8'($urandom); bb = 8'($urandom); s = 1'($urandom);
        bp = s ? ~bb : bb;
        full = {1'b0, aa} + {1'b0, bp} + {8'd0, s};
        es = full[7:0]; ec = full[8];
        eo = (aa[7] == bp[7]) && (es[7] != aa[7]);
        do_op(k, aa, bb, s, rs, rc, ro, lat);
        total++;
        if (lat !== ((k == 1) ? 4 : 1)) $display("FAIL lat_inst%0d: got %0d required %0d", k, lat, (k == 1) ? 4 : 1);
        else pass_cnt++;
        total++;
        if ({rs, rc, ro} !== {es, ec, eo})
          $display("FAIL rand_inst%0d a=%h b=%h sub=%b: got %h %b %b required %h %b %b", k, aa, bb, s, rs, rc, ro, es, ec, eo);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] rs; logic rc, ro; int lat, n;
    a = 8'h12; b = 8'h34; sub = 1'b0; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    n = 0;
    while (!out_valid_o[0] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n !== 8) $display("FAIL bp_latency: got %0d required 8", n);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      in_valid[0] = 1'b1; a = 8'hFF; b = 8'hFF;
      @(posedge clk); #1;
      total++;
      if ({out_valid_o[0], in_ready_o[0], sum_o[0], carry_o[0], ovf_o[0]} !== {1'b1, 1'b0, 8'h46, 1'b0, 1'b0})
        $display("FAIL bp_hold%0d: got ov=%b ir=%b sum=%h c=%b o=%b required 1 0 46 0 0",
                 i, out_valid_o[0], in_ready_o[0], sum_o[0], carry_o[0], ovf_o[0]);
      else pass_cnt++;
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    total++;
    if ({out_valid_o[0], in_ready_o[0]} !== 2'b01)
      $display("FAIL bp_release: got ov=%b ir=%b required 0 1", out_valid_o[0], in_ready_o[0]);
    else pass_cnt++;
    do_op(0, 8'h20, 8'h22, 1'b0, rs, rc, ro, lat);
    total++;
    if ({rs, rc, ro, lat} !== {8'h42, 1'b0, 1'b0, 32'd8})
      $display("FAIL back_to_back: got sum=%h c=%b o=%b lat=%0d required 42 0 0 8", rs, rc, ro, lat);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_op();
    logic [7:0] rs; logic rc, ro; int lat;
    logic seen;
    a = 8'h55; b = 8'h11; sub = 1'b0; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    total++;
    if ({out_valid_o[0], in_ready_o[0], sum_o[0], carry_o[0], ovf_o[0]} !== 12'd0)
      $display("FAIL midreset_clear: got ov=%b ir=%b sum=%h c=%b o=%b required all 0",
               out_valid_o[0], in_ready_o[0], sum_o[0], carry_o[0], ovf_o[0]);
    else pass_cnt++;
    @(posedge clk); #1;
    total++;
    if (in_ready_o[0] !== 1'b1) $display("FAIL midreset_idle: in_ready=%b required 1", in_ready_o[0]);
    else pass_cnt++;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid_o[0] !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    total++;
    if (seen !== 1'b0) $display("FAIL midreset_no_result: out_valid seen=%b required 0", seen);
    else pass_cnt++;
    do_op(0, 8'h10, 8'h20, 1'b0, rs, rc, ro, lat);
    total++;
    if ({rs, rc, ro, lat} !== {8'h30, 1'b0, 1'b0, 32'd8})
      $display("FAIL after_reset_op: got sum=%h c=%b o=%b lat=%0d required 30 0 0 8", rs, rc, ro, lat);
    else pass_cnt++;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0;
      out_ready[k] = 1'b0;
    end
    a = 8'h00; b = 8'h00; sub = 1'b0;
    rst_n = 1'b0;
    #1;
    test_reset();
    test_add();
    test_sub();
    test_digit_widths();
    test_backpressure();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
